// File: rtl/train_sequencer_if.sv
// Handshake bundle between the training sequencer and its host/datapath.
// master drives start/abort/epochs and the done strobes; slave is the sequencer.
interface train_sequencer_if #(
  parameter int LAYER_ADDR_WIDTH = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int EPOCH_WIDTH      = 16
);
  logic                        start;
  logic                        abort;
  logic [EPOCH_WIDTH-1:0]      epochs;
  logic                        fwd_done;
  logic                        err_done;
  logic                        bwd_done;
  logic                        fwd_start;
  logic                        err_start;
  logic                        bwd_start;
  logic [LAYER_ADDR_WIDTH-1:0] layer;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_addr;
  logic [EPOCH_WIDTH-1:0]      epoch_count;
  logic                        busy;
  logic                        done;

  modport master (
    output start, abort, epochs, fwd_done, err_done, bwd_done,
    input  fwd_start, err_start, bwd_start, layer, sample_addr, epoch_count, busy, done
  );

  modport slave (
    input  start, abort, epochs, fwd_done, err_done, bwd_done,
    output fwd_start, err_start, bwd_start, layer, sample_addr, epoch_count, busy, done
  );
endinterface

// File: rtl/train_sequencer.sv
// Training control FSM: forward over all layers, output error, then backward/update
// in reverse layer order, for every sample of every epoch. Sequencing only, no data.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start
// FWD_ISSUE | fwd_start pulse for current layer
// FWD_WAIT  | waiting for fwd_done
// ERR_ISSUE | err_start pulse for current sample
// ERR_WAIT  | waiting for err_done
// BWD_ISSUE | bwd_start pulse for current layer
// BWD_WAIT  | waiting for bwd_done
// DONE      | one-cycle done pulse, then IDLE
module train_sequencer #(
  parameter int LAYER_ADDR_WIDTH = 3,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 10,
  parameter int MAX_SAMPLES      = 1000,
  parameter int EPOCH_WIDTH      = 16
) (
  input logic              clk,
  input logic              rst,
  train_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FWD_ISSUE, FWD_WAIT, ERR_ISSUE, ERR_WAIT, BWD_ISSUE, BWD_WAIT, DONE
  } state_e;

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_LAST  = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE   = LAYER_ADDR_WIDTH'(1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_LAST = SAMPLE_ADDR_SIZE'(MAX_SAMPLES - 1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] SAMPLE_ONE  = SAMPLE_ADDR_SIZE'(1);
  localparam logic [EPOCH_WIDTH-1:0]      EPOCH_ONE   = EPOCH_WIDTH'(1);

  state_e                      state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_d;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_q, sample_d;
  logic [EPOCH_WIDTH-1:0]      epoch_q, epoch_d;
  logic [EPOCH_WIDTH-1:0]      epochs_lat_q, epochs_lat_d;
  logic                        fwd_start_q, fwd_start_d;
  logic                        err_start_q, err_start_d;
  logic                        bwd_start_q, bwd_start_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [EPOCH_WIDTH-1:0]      epoch_inc;

  assign epoch_inc = epoch_q + EPOCH_ONE;

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    sample_d     = sample_q;
    epoch_d      = epoch_q;
    epochs_lat_d = epochs_lat_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          epochs_lat_d = bus.epochs;
          layer_d      = '0;
          sample_d     = '0;
          epoch_d      = '0;
          state_d      = (bus.epochs == '0) ? DONE : FWD_ISSUE;
        end
      end
      FWD_ISSUE: state_d = FWD_WAIT;
      FWD_WAIT: begin
        if (bus.fwd_done) begin
          if (layer_q < LAYER_LAST) begin
            layer_d = layer_q + LAYER_ONE;
            state_d = FWD_ISSUE;
          end else begin
            state_d = ERR_ISSUE;
          end
        end
      end
      ERR_ISSUE: state_d = ERR_WAIT;
      ERR_WAIT: begin
        if (bus.err_done) begin
          layer_d = LAYER_LAST;
          state_d = BWD_ISSUE;
        end
      end
      BWD_ISSUE: state_d = BWD_WAIT;
      BWD_WAIT: begin
        if (bus.bwd_done) begin
          if (layer_q != '0) begin
            layer_d = layer_q - LAYER_ONE;
            state_d = BWD_ISSUE;
          end else if (sample_q < SAMPLE_LAST) begin
            sample_d = sample_q + SAMPLE_ONE;
            state_d  = FWD_ISSUE;
          end else begin
            sample_d = '0;
            epoch_d  = epoch_inc;
            state_d  = (epoch_inc == epochs_lat_q) ? DONE : FWD_ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort outranks any strobe and freezes the counters where they stand.
    if (bus.abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      layer_d  = layer_q;
      sample_d = sample_q;
      epoch_d  = epoch_q;
    end

    fwd_start_d = (state_d == FWD_ISSUE);
    err_start_d = (state_d == ERR_ISSUE);
    bwd_start_d = (state_d == BWD_ISSUE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      sample_q     <= '0;
      epoch_q      <= '0;
      epochs_lat_q <= '0;
      fwd_start_q  <= 1'b0;
      err_start_q  <= 1'b0;
      bwd_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      sample_q     <= sample_d;
      epoch_q      <= epoch_d;
      epochs_lat_q <= epochs_lat_d;
      fwd_start_q  <= fwd_start_d;
      err_start_q  <= err_start_d;
      bwd_start_q  <= bwd_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.fwd_start   = fwd_start_q;
  assign bus.err_start   = err_start_q;
  assign bus.bwd_start   = bwd_start_q;
  assign bus.layer       = layer_q;
  assign bus.sample_addr = sample_q;
  assign bus.epoch_count = epoch_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer with LAYER_MAX=3, MAX_SAMPLES=2.
// Cycle 0 is the cycle in which start is held high; outputs are sampled mid-cycle.
module tb_train_sequencer;
  localparam int LAW = 3;
  localparam int LM  = 3;
  localparam int SAS = 10;
  localparam int MS  = 2;
  localparam int EW  = 16;

  logic clk = 1'b0;
  logic rst;

  train_sequencer_if #(.LAYER_ADDR_WIDTH(LAW), .SAMPLE_ADDR_SIZE(SAS), .EPOCH_WIDTH(EW)) bus ();

  train_sequencer #(
    .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LM), .SAMPLE_ADDR_SIZE(SAS),
    .MAX_SAMPLES(MS), .EPOCH_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc;
  logic resp_en = 1'b0;
  logic pend_f = 1'b0, pend_e = 1'b0, pend_b = 1'b0;
  int p_kind[$], p_cyc[$], p_layer[$], p_sample[$], p_epoch[$];
  int done_cnt, done_at, busy_cnt, busy_first;
  int done_epoch, done_sample;

  task automatic clear_log();
    p_kind.delete(); p_cyc.delete(); p_layer.delete(); p_sample.delete(); p_epoch.delete();
    done_cnt = 0; done_at = -1; busy_cnt = 0; busy_first = -1;
    done_epoch = -1; done_sample = -1;
  endtask

  task automatic log_pulse(input int kind);
    p_kind.push_back(kind);
    p_cyc.push_back(cyc);
    p_layer.push_back(int'(bus.layer));
    p_sample.push_back(int'(bus.sample_addr));
    p_epoch.push_back(int'(bus.epoch_count));
  endtask

  // Records this cycle's outputs and plays the zero-latency responders.
  task automatic capture();
    if (bus.fwd_start) log_pulse(0);
    if (bus.err_start) log_pulse(1);
    if (bus.bwd_start) log_pulse(2);
    if (bus.done) begin
      done_cnt++; done_at = cyc;
      done_epoch = int'(bus.epoch_count); done_sample = int'(bus.sample_addr);
    end
    if (bus.busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = cyc;
    end
    if (resp_en) begin
      bus.fwd_done = pend_f; bus.err_done = pend_e; bus.bwd_done = pend_b;
    end
    pend_f = bus.fwd_start; pend_e = bus.err_start; pend_b = bus.bwd_start;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    capture();
  endtask

  task automatic begin_run(input logic [EW-1:0] e);
    @(negedge clk);
    cyc = 0;
    clear_log();
    bus.abort = 1'b0;
    capture();
    bus.epochs = e;
    bus.start  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 0; bus.abort = 0; bus.epochs = '0;
    bus.fwd_done = 0; bus.err_done = 0; bus.bwd_done = 0;
    @(negedge clk);
    chk_cnt++;
    if ({bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done});
    else pass_cnt++;
    chk_cnt++;
    if (bus.layer !== '0 || bus.sample_addr !== '0 || bus.epoch_count !== '0)
      $display("FAIL reset_counters: got layer=%0d sample=%0d epoch=%0d expected 0/0/0",
               bus.layer, bus.sample_addr, bus.epoch_count);
    else pass_cnt++;
    rst = 1'b1;
    cyc = 0;
    clear_log();
    resp_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk_cnt++;
    if (busy_cnt != 0 || p_kind.size() != 0)
      $display("FAIL reset_idle: got busy_cycles=%0d pulses=%0d expected 0/0", busy_cnt, p_kind.size());
    else pass_cnt++;
  endtask

  task automatic test_single_epoch();
    int ek, el;
    resp_en = 1'b1;
    begin_run(1);
    for (int k = 0; k < 60 && done_cnt == 0; k++) tick();
    chk_cnt++;
    if (done_cnt != 1 || done_at != 29)
      $display("FAIL one_epoch_done: got count=%0d cycle=%0d expected 1 at 29", done_cnt, done_at);
    else pass_cnt++;
    chk_cnt++;
    if (done_epoch != 1 || done_sample != 0)
      $display("FAIL one_epoch_counts: got epoch=%0d sample=%0d expected 1/0", done_epoch, done_sample);
    else pass_cnt++;
    chk_cnt++;
    if (p_kind.size() != 14)
      $display("FAIL one_epoch_pulses: got %0d expected 14", p_kind.size());
    else pass_cnt++;
    for (int i = 0; i < p_kind.size() && i < 14; i++) begin
      ek = (i % 7 < 3) ? 0 : ((i % 7 == 3) ? 1 : 2);
      el = (i % 7 < 3) ? (i % 7) : ((i % 7 == 3) ? 2 : 6 - (i % 7));
      chk_cnt++;
      if (p_kind[i] != ek || p_layer[i] != el || p_sample[i] != i / 7 || p_cyc[i] != 1 + 2 * i)
        $display("FAIL one_epoch_pulse%0d: got kind=%0d layer=%0d sample=%0d cyc=%0d expected %0d/%0d/%0d/%0d",
                 i, p_kind[i], p_layer[i], p_sample[i], p_cyc[i], ek, el, i / 7, 1 + 2 * i);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if (bus.busy !== 1'b0 || busy_cnt != 29 || busy_first != 1)
      $display("FAIL one_epoch_busy: got busy=%b cycles=%0d first=%0d expected 0/29/1",
               bus.busy, busy_cnt, busy_first);
    else pass_cnt++;
  endtask

  task automatic test_three_epochs();
    int ek, el;
    resp_en = 1'b1;
    begin_run(3);
    for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    chk_cnt++;
    if (done_cnt != 1 || done_at != 85)
      $display("FAIL three_epoch_done: got count=%0d cycle=%0d expected 1 at 85", done_cnt, done_at);
    else pass_cnt++;
    chk_cnt++;
    if (done_epoch != 3 || done_sample != 0)
      $display("FAIL three_epoch_counts: got epoch=%0d sample=%0d expected 3/0", done_epoch, done_sample);
    else pass_cnt++;
    chk_cnt++;
    if (p_kind.size() != 42)
      $display("FAIL three_epoch_pulses: got %0d expected 42", p_kind.size());
    else pass_cnt++;
    for (int i = 0; i < p_kind.size() && i < 42; i++) begin
      ek = (i % 7 < 3) ? 0 : ((i % 7 == 3) ? 1 : 2);
      el = (i % 7 < 3) ? (i % 7) : ((i % 7 == 3) ? 2 : 6 - (i % 7));
      chk_cnt++;
      if (p_kind[i] != ek || p_layer[i] != el || p_sample[i] != (i / 7) % 2 ||
          p_epoch[i] != i / 14 || p_cyc[i] != 1 + 2 * i)
        $display("FAIL three_epoch_pulse%0d: got kind=%0d layer=%0d sample=%0d epoch=%0d cyc=%0d expected %0d/%0d/%0d/%0d/%0d",
                 i, p_kind[i], p_layer[i], p_sample[i], p_epoch[i], p_cyc[i],
                 ek, el, (i / 7) % 2, i / 14, 1 + 2 * i);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_epochs();
    resp_en = 1'b1;
    begin_run(0);
    for (int k = 0; k < 5; k++) tick();
    chk_cnt++;
    if (done_cnt != 1 || done_at != 1 || done_epoch != 0)
      $display("FAIL zero_epoch_done: got count=%0d cycle=%0d epoch=%0d expected 1 at 1, epoch 0",
               done_cnt, done_at, done_epoch);
    else pass_cnt++;
    chk_cnt++;
    if (p_kind.size() != 0)
      $display("FAIL zero_epoch_pulses: got %0d expected 0", p_kind.size());
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt != 1 || busy_first != 1)
      $display("FAIL zero_epoch_busy: got cycles=%0d first=%0d expected 1/1", busy_cnt, busy_first);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    resp_en = 1'b0;
    bus.fwd_done = 0; bus.err_done = 0; bus.bwd_done = 0;
    begin_run(1);
    tick();
    chk_cnt++;
    if (bus.fwd_start !== 1'b1 || bus.layer !== 3'd0)
      $display("FAIL spur_first_fwd: got fwd_start=%b layer=%0d expected 1/0", bus.fwd_start, bus.layer);
    else pass_cnt++;
    bus.fwd_done = 1'b1;
    tick();
    chk_cnt++;
    if (bus.fwd_start !== 1'b0 || bus.layer !== 3'd0 || bus.busy !== 1'b1)
      $display("FAIL spur_coincident: got fwd_start=%b layer=%0d busy=%b expected 0/0/1",
               bus.fwd_start, bus.layer, bus.busy);
    else pass_cnt++;
    bus.fwd_done = 1'b0; bus.err_done = 1'b1; bus.bwd_done = 1'b1;
    bus.start = 1'b1; bus.epochs = 16'd5;
    tick();
    chk_cnt++;
    if ({bus.fwd_start, bus.err_start, bus.bwd_start} !== 3'b000 || bus.layer !== 3'd0)
      $display("FAIL spur_wrong_strobe: got pulses=%b layer=%0d expected 000/0",
               {bus.fwd_start, bus.err_start, bus.bwd_start}, bus.layer);
    else pass_cnt++;
    bus.err_done = 1'b0; bus.bwd_done = 1'b0; bus.fwd_done = 1'b1;
    tick();
    chk_cnt++;
    if (bus.fwd_start !== 1'b1 || bus.layer !== 3'd1)
      $display("FAIL spur_advance: got fwd_start=%b layer=%0d expected 1/1", bus.fwd_start, bus.layer);
    else pass_cnt++;
    bus.fwd_done = 1'b0;
    resp_en = 1'b1;
    for (int k = 0; k < 100 && done_cnt == 0; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    chk_cnt++;
    if (done_cnt != 1 || done_at != 30 || done_epoch != 1)
      $display("FAIL spur_epochs_latched: got count=%0d cycle=%0d epoch=%0d expected 1 at 30, epoch 1",
               done_cnt, done_at, done_epoch);
    else pass_cnt++;
    chk_cnt++;
    if (p_kind.size() != 14 || bus.busy !== 1'b0)
      $display("FAIL spur_pulses: got pulses=%0d busy=%b expected 14/0", p_kind.size(), bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    resp_en = 1'b1;
    begin_run(1);
    while (cyc < 24) tick();
    chk_cnt++;
    if (p_kind.size() != 12 || p_kind[p_kind.size()-1] != 2 || p_cyc[p_cyc.size()-1] != 23 ||
        p_sample[p_sample.size()-1] != 1)
      $display("FAIL abort_setup: got pulses=%0d last_cyc=%0d expected 12 ending bwd at 23",
               p_kind.size(), (p_cyc.size() > 0) ? p_cyc[p_cyc.size()-1] : -1);
    else pass_cnt++;
    bus.abort = 1'b1;
    tick();
    chk_cnt++;
    if ({bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done} !== 5'b0)
      $display("FAIL abort_idle: got pulses/busy/done=%b expected 00000",
               {bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done});
    else pass_cnt++;
    chk_cnt++;
    if (bus.sample_addr !== 10'd1 || bus.layer !== 3'd2 || bus.epoch_count !== 16'd0)
      $display("FAIL abort_hold: got sample=%0d layer=%0d epoch=%0d expected 1/2/0",
               bus.sample_addr, bus.layer, bus.epoch_count);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) tick();
    chk_cnt++;
    if (done_cnt != 0 || p_kind.size() != 12)
      $display("FAIL abort_quiet: got done=%0d pulses=%0d expected 0/12", done_cnt, p_kind.size());
    else pass_cnt++;
    begin_run(1);
    tick();
    chk_cnt++;
    if (bus.fwd_start !== 1'b1 || bus.layer !== 3'd0 || bus.sample_addr !== 10'd0)
      $display("FAIL abort_restart: got fwd_start=%b layer=%0d sample=%0d expected 1/0/0",
               bus.fwd_start, bus.layer, bus.sample_addr);
    else pass_cnt++;
    for (int k = 0; k < 60 && done_cnt == 0; k++) tick();
    chk_cnt++;
    if (done_cnt != 1 || done_at != 29)
      $display("FAIL abort_rerun_done: got count=%0d cycle=%0d expected 1 at 29", done_cnt, done_at);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b1;
    begin_run(1);
    while (cyc < 4) tick();
    chk_cnt++;
    if (bus.layer !== 3'd1 || bus.busy !== 1'b1)
      $display("FAIL rst_mid_setup: got layer=%0d busy=%b expected 1/1", bus.layer, bus.busy);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done} !== 5'b0 ||
        bus.layer !== '0 || bus.sample_addr !== '0 || bus.epoch_count !== '0)
      $display("FAIL rst_mid_async: got flags=%b layer=%0d sample=%0d epoch=%0d expected all 0",
               {bus.fwd_start, bus.err_start, bus.bwd_start, bus.busy, bus.done},
               bus.layer, bus.sample_addr, bus.epoch_count);
    else pass_cnt++;
    resp_en = 1'b0;
    bus.fwd_done = 0; bus.err_done = 0; bus.bwd_done = 0;
    pend_f = 0; pend_e = 0; pend_b = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    clear_log();
    resp_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk_cnt++;
    if (p_kind.size() != 0 || busy_cnt != 0)
      $display("FAIL rst_mid_quiet: got pulses=%0d busy_cycles=%0d expected 0/0", p_kind.size(), busy_cnt);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_epoch();
    test_three_epochs();
    test_zero_epochs();
    test_spurious();
    test_abort();
    test_reset_mid();
    test_single_epoch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/train_sequencer.md
# train_sequencer

Control FSM that runs training for the layer-multiplexed backpropagation datapath. It walks every sample of every epoch through a forward pass over layers `0..LAYER_MAX-1`, an output-error step, and a backward/weight-update pass over layers `LAYER_MAX-1..0`. It sits between the top-level `start` and the shared layer datapath, issuing one-cycle start pulses and waiting on done strobes. It never touches data, only sequencing, layer select and sample address.

## Interface
- `LAYER_ADDR_WIDTH`, 3, width of the `layer` select.
- `LAYER_MAX`, 3, number of layers; must satisfy 1 ≤ `LAYER_MAX` ≤ 2^`LAYER_ADDR_WIDTH`.
- `SAMPLE_ADDR_SIZE`, 10, width of `sample_addr`.
- `MAX_SAMPLES`, 1000, samples per epoch; must satisfy 1 ≤ `MAX_SAMPLES` ≤ 2^`SAMPLE_ADDR_SIZE`.
- `EPOCH_WIDTH`, 16, width of the epoch count and epoch counter.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin training; honoured only in IDLE.
- `abort`  in  1  synchronous stop; returns to IDLE next cycle.
- `epochs`  in  `EPOCH_WIDTH`  epoch count, latched on accepted `start`.
- `fwd_done`  in  1  forward layer complete strobe.
- `err_done`  in  1  output-error computation complete strobe.
- `bwd_done`  in  1  backward delta plus weight update for the layer complete.
- `fwd_start`  out  1  one-cycle pulse: run forward for `layer`.
- `err_start`  out  1  one-cycle pulse: compute output error for `sample_addr`.
- `bwd_start`  out  1  one-cycle pulse: run backward and update for `layer`.
- `layer`  out  `LAYER_ADDR_WIDTH`  active layer index.
- `sample_addr`  out  `SAMPLE_ADDR_SIZE`  current sample index to inputs/targets memories.
- `epoch_count`  out  `EPOCH_WIDTH`  completed epochs.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when all epochs finish.

## Operation
- States: IDLE, FWD_ISSUE, FWD_WAIT, ERR_ISSUE, ERR_WAIT, BWD_ISSUE, BWD_WAIT, DONE.
- IDLE + `start`:
  - Latch `epochs`; clear `layer`, `sample_addr` and `epoch_count`.
  - If `epochs`==0, go to DONE; otherwise go to FWD_ISSUE.
- *_ISSUE states assert their start pulse for exactly one cycle, then go to the matching *_WAIT state.
- Done strobes are sampled only in the matching WAIT state. Strobes in any other state, or non-matching strobes, are ignored.
- FWD_WAIT + `fwd_done`:
  - If `layer` < `LAYER_MAX`-1: increment `layer` and go to FWD_ISSUE.
  - Else go to ERR_ISSUE; `layer` is held at `LAYER_MAX`-1.
- ERR_WAIT + `err_done`: go to BWD_ISSUE with `layer`=`LAYER_MAX`-1.
- BWD_WAIT + `bwd_done`:
  - If `layer` > 0: decrement `layer` and go to BWD_ISSUE.
  - Else, if `sample_addr` < `MAX_SAMPLES`-1: increment `sample_addr` and go to FWD_ISSUE.
  - Else (epoch wrap): set `sample_addr`=0 and increment `epoch_count`.
    - If the new `epoch_count`==`epochs_latched`, go to DONE.
    - Otherwise go to FWD_ISSUE.
  - `layer`=0 on every transition to FWD_ISSUE.
- DONE: `done`=1 for one cycle, then IDLE. `epoch_count` and `sample_addr` hold until the next start.
- `abort` (any non-IDLE state): go to IDLE next cycle with no pulse and no `done`. Counters hold their values. `abort` has priority over done strobes.
- `start` while busy is ignored; `epochs` is not re-latched.
- Reset (asserted asynchronously, including mid-pass): state=IDLE and all outputs=0 immediately; no pulses are issued until a new `start`.

## Timing
- Accepted `start` at cycle T: first `fwd_start` at T+1 (`layer`=0, `sample_addr`=0).
- A done strobe sampled at cycle t causes the next start pulse at t+1, with `layer`/`sample_addr` already updated in that cycle.
- Minimum step is 2 cycles (ISSUE + one WAIT).
- Steps per sample are 2·`LAYER_MAX`+1.
- With zero-wait responders (strobe in the first WAIT cycle), a sample takes 2·(2·`LAYER_MAX`+1) cycles.
- Final `bwd_done` at t: `done` at t+1, `busy` falls at t+2.
- `epochs`==0: `start` at T, `done` at T+1, no start pulses.
- `sample_addr` changes only on `bwd_done` at `layer` 0, so the input/target memories see a stable address for the whole sample.

## Test plan
- `LAYER_MAX`=3, `MAX_SAMPLES`=2, `epochs`=1, responders strobe done 1 cycle after each pulse, `start` at cycle 0:
  - Pulses at cycles 1,3,…,27 in the order fwd L0,L1,L2, err, bwd L2,L1,L0, repeated for sample 1.
  - `done` at 29; `epoch_count`=1.
- Same setup with `epochs`=3: 42 start pulses in total; `sample_addr` goes 0,1,0,1,0,1; `epoch_count` steps 1→2→3; single `done`.
- `epochs`=0: `done` at cycle 1, no `fwd_start`/`err_start`/`bwd_start`, `busy` high only at cycle 1.
- Spurious strobes:
  - `bwd_done` and `err_done` during FWD_WAIT are ignored.
  - `fwd_done` coincident with `fwd_start` is ignored.
  - A second `start` mid-run leaves `epochs_latched` unchanged.
- `abort` in BWD_WAIT of sample 1: IDLE next cycle, no `done`, `sample_addr`=1 held. A new `start` restarts from sample 0, layer 0.
- `rst` low mid-forward at layer 1: all outputs 0 asynchronously, no pulse after release until `start`. After `start`, the sequence matches the first scenario exactly.
